mc_control_fsm: RTL

Multicycle control unit for the RISC-V core. It sequences a shared-ALU, unified-memory datapath through fetch, decode, execute, memory and writeback steps, and drives every mux select and write enable from a Moore state machine plus a combinational ALU decoder. It sits beside the datapath, in place of the single-cycle decoder, and is fed by the instruction register and the ALU zero flag.

---
 rtl/mc_control_fsm_pkg.sv | 83 ++++++++
 rtl/mc_control_fsm_if.sv | 46 ++++
 rtl/mc_control_fsm_alu_decoder.sv | 39 +++
 rtl/mc_control_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : mc_ctrl_pkg                                              |
// | Description : State, opcode and datapath-select encodings shared by    |
// |               the multicycle control unit, its ALU decoder and the     |
// |               datapath.                                                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package mc_ctrl_pkg;

  // The numeric order matters: it is what appears on state_o.
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    LUI       = 4'd8,
    ALUWB     = 4'd9,
    BRANCH    = 4'd10,
    JAL       = 4'd11,
    JALR      = 4'd12,
    JALR_LINK = 4'd13,
    TRAP      = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_SLT = 3'b101;

  localparam logic [2:0] C_IMM_I = 3'b000;
  localparam logic [2:0] C_IMM_S = 3'b001;
  localparam logic [2:0] C_IMM_B = 3'b010;
  localparam logic [2:0] C_IMM_J = 3'b011;
  localparam logic [2:0] C_IMM_U = 3'b100;

  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_MEMDATA   = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  localparam logic [1:0] C_SRCA_PC    = 2'b00;
  localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] C_SRCA_RD1   = 2'b10;
  localparam logic [1:0] C_SRCA_ZERO  = 2'b11;

  localparam logic [1:0] C_SRCB_RD2  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; I-type covers loads, jalr,
  // ALU-immediates and anything without an immediate.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      C_OP_STORE:  return C_IMM_S;
      C_OP_BRANCH: return C_IMM_B;
      C_OP_JAL:    return C_IMM_J;
      C_OP_LUI:    return C_IMM_U;
      default:     return C_IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : mc_control_fsm_if                                        |
// | Description : Bundle between the control unit and the datapath.       |
// |   master (control unit): in  op, funct3, funct7b5, zero               |
// |                          out pc_write, adr_src, mem_write, ir_write,  |
// |                              reg_write, result_src, alu_src_a/b,      |
// |                              imm_src, alu_control, state_o, retire,   |
// |                              illegal_op                               |
// |   slave (datapath)     : the mirror image                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic       retire;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, state_o, retire,
           illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, state_o, retire,
           illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm_alu_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mc_alu_decoder                                           |
// | Description : Combinational ALU operation decoder.                    |
// |   in  alu_op (add/sub/funct), funct3, funct7b5, op5                   |
// |   out alu_control                                                     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = C_ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = C_ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // instr[30] only selects sub for register-register ops; for addi
          // it is part of the immediate.
          3'b000:  alu_control = (op5 && funct7b5) ? C_ALU_SUB : C_ALU_ADD;
          3'b010:  alu_control = C_ALU_SLT;
          3'b110:  alu_control = C_ALU_OR;
          3'b111:  alu_control = C_ALU_AND;
          default: alu_control = C_ALU_ADD;
        endcase
      end
      default: alu_control = C_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mc_control_fsm                                           |
// | Description : Multicycle RISC-V control unit. Moore FSM sequencing     |
// |               fetch/decode/execute/memory/writeback plus ALU decoder. |
// |   in  clk  core clock                                                 |
// |   in  rst  asynchronous active-low reset                              |
// |   bus mc_control_fsm_if.master: instruction fields and zero flag in,  |
// |       datapath selects/enables, state_o, retire, illegal_op out       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  alu_op_t    w_alu_op;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_retire;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_imm_src;
  logic [2:0] w_alu_control;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = FETCH;
    w_alu_op     = ALUOP_ADD;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_result_src = C_RES_ALUOUT;
    w_alu_src_a  = C_SRCA_PC;
    w_alu_src_b  = C_SRCB_RD2;
    w_imm_src    = C_IMM_I;
    case (r_state)
      FETCH: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_alu_src_b  = C_SRCB_FOUR;
        w_result_src = C_RES_ALURESULT;
        w_next_state = DECODE;
      end
      DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jal target.
        w_alu_src_a = C_SRCA_OLDPC;
        w_alu_src_b = C_SRCB_IMM;
        w_imm_src   = imm_src_of(bus.op);
        case (bus.op)
          C_OP_LOAD, C_OP_STORE: w_next_state = MEMADR;
          C_OP_RTYPE:            w_next_state = EXEC_R;
          C_OP_ITYPE:            w_next_state = EXEC_I;
          C_OP_BRANCH:           w_next_state = BRANCH;
          C_OP_JAL:              w_next_state = JAL;
          C_OP_JALR:             w_next_state = JALR;
          C_OP_LUI:              w_next_state = LUI;
          default:               w_next_state = TRAP;
        endcase
      end
      MEMADR: begin
        // The immediate format is kept alive in every state that feeds
        // ImmExt into the ALU so sw gets its S-type offset.
        w_alu_src_a  = C_SRCA_RD1;
        w_alu_src_b  = C_SRCB_IMM;
        w_imm_src    = imm_src_of(bus.op);
        w_next_state = (bus.op == C_OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        w_adr_src    = 1'b1;
        w_next_state = MEMWB;
      end
      MEMWB: begin
        w_result_src = C_RES_MEMDATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = 1'b1;
      end
      EXEC_R: begin
        w_alu_src_a  = C_SRCA_RD1;
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = ALUWB;
      end
      EXEC_I: begin
        w_alu_src_a  = C_SRCA_RD1;
        w_alu_src_b  = C_SRCB_IMM;
        w_imm_src    = imm_src_of(bus.op);
        w_alu_op     = ALUOP_FUNCT;
        w_next_state = ALUWB;
      end
      LUI: begin
        w_alu_src_a  = C_SRCA_ZERO;
        w_alu_src_b  = C_SRCB_IMM;
        w_imm_src    = C_IMM_U;
        w_next_state = ALUWB;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      BRANCH: begin
        // funct3[0] distinguishes bne from beq.
        w_alu_src_a = C_SRCA_RD1;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = bus.zero ^ bus.funct3[0];
        w_retire    = 1'b1;
      end
      JAL: begin
        w_alu_src_a  = C_SRCA_OLDPC;
        w_alu_src_b  = C_SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = ALUWB;
      end
      JALR: begin
        w_alu_src_a  = C_SRCA_RD1;
        w_alu_src_b  = C_SRCB_IMM;
        w_imm_src    = imm_src_of(bus.op);
        w_result_src = C_RES_ALURESULT;
        w_pc_write   = 1'b1;
        w_next_state = JALR_LINK;
      end
      JALR_LINK: begin
        w_alu_src_a  = C_SRCA_OLDPC;
        w_alu_src_b  = C_SRCB_FOUR;
        w_result_src = C_RES_ALURESULT;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      TRAP:    w_next_state = TRAP;
      default: w_next_state = FETCH;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (w_alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (w_alu_control)
  );

  // The reset state is FETCH, whose actions must not leak while rst is low,
  // so every output is forced quiet by rst itself rather than by the state.
  assign bus.pc_write    = rst & w_pc_write;
  assign bus.adr_src     = rst & w_adr_src;
  assign bus.mem_write   = rst & w_mem_write;
  assign bus.ir_write    = rst & w_ir_write;
  assign bus.reg_write   = rst & w_reg_write;
  assign bus.retire      = rst & w_retire;
  assign bus.result_src  = rst ? w_result_src  : 2'b00;
  assign bus.alu_src_a   = rst ? w_alu_src_a   : 2'b00;
  assign bus.alu_src_b   = rst ? w_alu_src_b   : 2'b00;
  assign bus.imm_src     = rst ? w_imm_src     : 3'b000;
  assign bus.alu_control = rst ? w_alu_control : 3'b000;
  assign bus.state_o     = r_state;
  // TRAP is absorbing until reset, so this is sticky by construction.
  assign bus.illegal_op  = (r_state == TRAP);

endmodule
`default_nettype wire
